// File: rtl/mem_load_unit_pkg.sv
// Shared definitions for the data-memory load path: RISC-V load funct3 codes,
// FSM state encoding and the alignment/legality rule for a load request.
package mem_load_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Byte loads are always aligned; halves need an even address, words a multiple of 4.
  function automatic logic is_legal(input logic [2:0] funct3, input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~off[0];
      F3_LW:         ok = (off == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of an aligned memory word and sign- or
// zero-extends it to 32 bits according to the load funct3.
module load_extend
  import mem_load_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'b0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'b0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Load side of the data-memory path: issues a req/ack read, extends the result
// and returns a one-cycle writeback pulse while stalling the pipeline.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  input  logic [4:0]  ld_rd,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        ld_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   addr_q;
  logic [2:0]    funct3_q;
  logic [4:0]    rd_q;
  logic [31:0]   ext_data;
  logic          req_legal;
  logic          timed_out;

  assign req_legal = is_legal(ld_funct3, ld_addr[1:0]);
  assign timed_out = (count == CW'(TIMEOUT));

  // A squashed load still in DRAIN no longer holds the pipeline.
  assign stall = ((state == ST_IDLE) && ld_valid && req_legal && !flush) || (state == ST_WAIT);

  load_extend u_extend (
    .rdata  (mem_rdata),
    .off    (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      addr_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      ld_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      ld_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ld_valid && !flush) begin
            if (req_legal) begin
              state    <= ST_WAIT;
              count    <= '0;
              addr_q   <= ld_addr;
              funct3_q <= ld_funct3;
              rd_q     <= ld_rd;
              mem_addr <= {ld_addr[31:2], 2'b00};
              mem_req  <= 1'b1;
            end else begin
              ld_err <= 1'b1;
            end
          end
        end
        ST_WAIT, ST_DRAIN: begin
          // The request is only withdrawn on ack or timeout, even once squashed.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if ((state == ST_WAIT) && !flush) begin
              state    <= ST_DONE;
              wb_valid <= 1'b1;
              wb_data  <= ext_data;
              wb_rd    <= rd_q;
            end else begin
              state <= ST_IDLE;
            end
          end else if (timed_out) begin
            mem_req <= 1'b0;
            state   <= ST_IDLE;
            ld_err  <= (state == ST_WAIT) && !flush;
          end else begin
            count <= count + 1'b1;
            if (flush) state <= ST_DRAIN;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
